// File: rtl/shifter.sv
// 16-bit barrel shifter (SLL / SRA) built from four log-stepped mux stages,
// with a combinational result and a registered copy for pipelined consumers.
module shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] Shift_In,
  input  logic [3:0]  Shift_Val,
  input  logic        Mode,
  output logic [15:0] Shift_Out,
  output logic [15:0] Shift_Out_q
);

  logic [15:0] w_stage [5];
  logic        w_fill;
  logic [15:0] r_shift_q;

  assign w_fill     = Mode & Shift_In[15];
  assign w_stage[0] = Shift_In;

  // Stage k moves data by 2**k; Mode picks left (toward MSB) or right neighbour.
  for (genvar gs = 0; gs < 4; gs++) begin : g_stage
    localparam int S = 2 ** gs;
    logic [15:0] w_moved;
    for (genvar gb = 0; gb < 16; gb++) begin : g_bit
      if (gb >= S && gb + S <= 15) begin : g_mid
        assign w_moved[gb] = Mode ? w_stage[gs][gb+S] : w_stage[gs][gb-S];
      end else if (gb >= S) begin : g_top
        assign w_moved[gb] = Mode ? w_fill : w_stage[gs][gb-S];
      end else begin : g_low
        assign w_moved[gb] = Mode ? w_stage[gs][gb+S] : 1'b0;
      end
    end
    assign w_stage[gs+1] = Shift_Val[gs] ? w_moved : w_stage[gs];
  end

  assign Shift_Out = w_stage[4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_shift_q <= 16'h0000;
    else        r_shift_q <= Shift_Out;
  end

  assign Shift_Out_q = r_shift_q;

endmodule

// File: tb/tb_shifter.sv
// Self-checking bench for shifter: directed corner cases, reset behaviour of
// the registered copy, and random vectors against an arithmetic reference.
module tb_shifter;

  logic        clk;
  logic        rst_n;
  logic [15:0] Shift_In;
  logic [3:0]  Shift_Val;
  logic        Mode;
  logic [15:0] Shift_Out;
  logic [15:0] Shift_Out_q;

  int checks   = 0;
  int failures = 0;

  shifter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Shift_In   (Shift_In),
    .Shift_Val  (Shift_Val),
    .Mode       (Mode),
    .Shift_Out  (Shift_Out),
    .Shift_Out_q(Shift_Out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: SLL as multiply modulo 2^16, SRA as floor division of the signed value.
  function automatic logic [15:0] ref_shift(input logic [15:0] in, input int val, input logic mode);
    int d, v, r;
    d = 2 ** val;
    if (!mode) begin
      r = (int'(in) * d) % 65536;
    end else begin
      v = (in >= 16'h8000) ? int'(in) - 65536 : int'(in);
      if (v >= 0) r = v / d;
      else        r = -((-v + d - 1) / d);
      if (r < 0) r = r + 65536;
    end
    return r[15:0];
  endfunction

  task automatic apply_check_comb(input logic [15:0] in, input int val, input logic mode,
                                  input logic [15:0] exp, input string name);
    Shift_In  = in;
    Shift_Val = 4'(val);
    Mode      = mode;
    #2;
    checks++;
    if (Shift_Out !== exp) begin
      failures++;
      $display("FAIL %s: in=%h val=%0d mode=%0d got=%h expected=%h", name, in, val, mode, Shift_Out, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Shift_In = 16'hFFFF; Shift_Val = 4'd0; Mode = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (Shift_Out_q !== 16'h0000) begin
      failures++;
      $display("FAIL reset_q: got=%h expected=0000", Shift_Out_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sll_sweep();
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      apply_check_comb(16'h0001, v, 1'b0, ref_shift(16'h0001, v, 1'b0), "sll_sweep_model");
      checks++;
      if (Shift_Out !== 16'(2 ** v)) begin
        failures++;
        $display("FAIL sll_sweep_const: val=%0d got=%h expected=%h", v, Shift_Out, 16'(2 ** v));
      end
    end
  endtask

  task automatic test_sra_directed();
    @(negedge clk);
    apply_check_comb(16'h8000, 1,  1'b1, 16'hC000, "sra_8000_1");
    apply_check_comb(16'h8000, 4,  1'b1, 16'hF800, "sra_8000_4");
    apply_check_comb(16'h8000, 15, 1'b1, 16'hFFFF, "sra_8000_15");
    apply_check_comb(16'h7FFF, 3,  1'b1, 16'h0FFF, "sra_7fff_3");
    apply_check_comb(16'h7FFF, 15, 1'b1, 16'h0000, "sra_7fff_15");
    apply_check_comb(16'h4000, 15, 1'b0, 16'h0000, "sll_4000_15");
    apply_check_comb(16'h0003, 15, 1'b0, 16'h8000, "sll_0003_15");
  endtask

  task automatic test_identity();
    @(negedge clk);
    apply_check_comb(16'hA5C3, 0, 1'b0, 16'hA5C3, "identity_sll");
    apply_check_comb(16'hA5C3, 0, 1'b1, 16'hA5C3, "identity_sra");
    apply_check_comb(16'hA5C3, 8, 1'b0, 16'hC300, "sll_a5c3_8");
    apply_check_comb(16'hA5C3, 8, 1'b1, 16'hFFA5, "sra_a5c3_8");
  endtask

  task automatic test_registered();
    @(negedge clk);
    Shift_In = 16'h00FF; Shift_Val = 4'd4; Mode = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (Shift_Out_q !== 16'h0FF0) begin
      failures++;
      $display("FAIL q_capture: got=%h expected=0ff0", Shift_Out_q);
    end
    // Async reset mid-cycle, no edge in between.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (Shift_Out_q !== 16'h0000) begin
      failures++;
      $display("FAIL q_async_reset: got=%h expected=0000", Shift_Out_q);
    end
    @(posedge clk); #1;
    checks++;
    if (Shift_Out_q !== 16'h0000) begin
      failures++;
      $display("FAIL q_reset_held: got=%h expected=0000", Shift_Out_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    Shift_In = 16'h1234; Shift_Val = 4'd4; Mode = 1'b0;
    #2;
    checks++;
    if (Shift_Out_q !== 16'h0000) begin
      failures++;
      $display("FAIL q_before_first_edge: got=%h expected=0000", Shift_Out_q);
    end
    @(posedge clk); #1;
    checks++;
    if (Shift_Out_q !== 16'h2340) begin
      failures++;
      $display("FAIL q_after_release: got=%h expected=2340", Shift_Out_q);
    end
  endtask

  task automatic test_random();
    logic [15:0] in, exp, prev_exp;
    int val;
    logic mode;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      in   = 16'($urandom);
      val  = int'($urandom_range(0, 15));
      mode = 1'($urandom);
      exp  = ref_shift(in, val, mode);
      apply_check_comb(in, val, mode, exp, "random_comb");
      if (mode) begin
        checks++;
        if (Shift_Out[15] !== in[15]) begin
          failures++;
          $display("FAIL random_sra_sign: in=%h val=%0d got=%h", in, val, Shift_Out);
        end
      end
      prev_exp = exp;
      @(posedge clk); #1;
      checks++;
      if (Shift_Out_q !== prev_exp) begin
        failures++;
        $display("FAIL random_q: in=%h val=%0d mode=%0d got=%h expected=%h", in, val, mode, Shift_Out_q, prev_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sll_sweep();
    test_sra_directed();
    test_identity();
    test_registered();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
